// File: rtl/pattern_serializer_pkg.sv
// pattern_serializer_pkg: state encoding shared by the serializer and the detector family
package pattern_serializer_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT,
    ST_GAP   = S_GAP,
    ST_DONE  = S_DONE
  } state_t;
endpackage

// File: rtl/pattern_serializer_if.sv
// pattern_serializer_if: control handshake and serial stream of the pattern serializer
// master: start, abort, pattern, reps out; dout, dout_valid, frame_start, busy, done in
// slave:  the same signals with directions reversed
interface pattern_serializer_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] reps;
  logic             dout;
  logic             dout_valid;
  logic             frame_start;
  logic             busy;
  logic             done;
  modport master (
    output start, abort, pattern, reps,
    input  dout, dout_valid, frame_start, busy, done
  );
  modport slave (
    input  start, abort, pattern, reps,
    output dout, dout_valid, frame_start, busy, done
  );
endinterface

// File: rtl/pattern_serializer_piso_shift.sv
// piso_shift: loadable parallel-in/serial-out register, MSB first, zero-filled
// clk, rst (sync, active-low); load_i/data_i parallel load; shift_en_i shift left; msb_o current bit
module piso_shift #(
  parameter int PAT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_en_i,
  input  logic [PAT_W-1:0] data_i,
  output logic             msb_o
);
  logic [PAT_W-1:0] sr_q;
  always_ff @(posedge clk)
    if (!rst) sr_q <= '0;
    else if (load_i) sr_q <= data_i;
    else if (shift_en_i) sr_q <= {sr_q[PAT_W-2:0], 1'b0};
  assign msb_o = sr_q[PAT_W-1];
endmodule

// File: rtl/pattern_serializer.sv
// pattern_serializer: sends a latched pattern MSB first reps times with GAP idle cycles between
// clk, rst (sync, active-low); bus (slave): start/pattern/reps/abort in, dout/dout_valid/frame_start/busy/done out
module pattern_serializer
  import pattern_serializer_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 4,
  parameter int GAP   = 2
) (
  input logic                 clk,
  input logic                 rst,
  pattern_serializer_if.slave bus
);
  localparam int BW = $clog2(PAT_W);
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  state_t           state_q, state_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [PAT_W-1:0] shadow_q, shadow_d, load_val;
  logic             load, shift, accept, msb;
  logic             valid_q, frame_q, busy_q, done_q;
  assign accept = bus.start & ~bus.abort;
  // The shift register is zero-filled, so its MSB is 0 whenever no pattern bit is
  // being sent; clearing it on abort and on reps==0 keeps dout at 0 outside SHIFT.
  piso_shift #(.PAT_W(PAT_W)) u_piso (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .shift_en_i(shift),
    .data_i    (load_val),
    .msb_o     (msb)
  );
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    rep_d    = rep_q;
    gap_d    = gap_q;
    shadow_d = shadow_q;
    load     = 1'b0;
    load_val = shadow_q;
    shift    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE:
        if (accept) begin
          shadow_d = bus.pattern;
          rep_d    = bus.reps;
          bit_d    = '0;
          gap_d    = '0;
          load     = 1'b1;
          load_val = bus.reps != '0 ? bus.pattern : '0;
          state_d  = bus.reps != '0 ? ST_SHIFT : ST_DONE;
        end else state_d = ST_IDLE;
      ST_SHIFT:
        if (bus.abort) begin
          state_d  = ST_IDLE;
          load     = 1'b1;
          load_val = '0;
          bit_d    = '0;
        end else if (bit_q == BW'(PAT_W - 1)) begin
          rep_d   = rep_q - 1'b1;
          bit_d   = '0;
          gap_d   = '0;
          load    = rep_q != CNT_W'(1) && GAP == 0;
          shift   = !load;
          state_d = rep_q == CNT_W'(1) ? ST_DONE : (GAP == 0 ? ST_SHIFT : ST_GAP);
        end else begin
          bit_d = bit_q + 1'b1;
          shift = 1'b1;
        end
      ST_GAP:
        if (bus.abort) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else if (gap_q == GW'(GAP - 1)) begin
          load    = 1'b1;
          gap_d   = '0;
          state_d = ST_SHIFT;
        end else gap_d = gap_q + 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state_q  <= ST_IDLE;
      bit_q    <= '0;
      rep_q    <= '0;
      gap_q    <= '0;
      shadow_q <= '0;
      valid_q  <= 1'b0;
      frame_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      rep_q    <= rep_d;
      gap_q    <= gap_d;
      shadow_q <= shadow_d;
      valid_q  <= state_d == ST_SHIFT;
      frame_q  <= state_d == ST_SHIFT && bit_d == '0;
      busy_q   <= state_d == ST_SHIFT || state_d == ST_GAP;
      done_q   <= state_d == ST_DONE;
    end
  assign bus.dout        = msb;
  assign bus.dout_valid  = valid_q;
  assign bus.frame_start = frame_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_pattern_serializer.sv
// tb_pattern_serializer: directed vectors against GAP=2 and GAP=0 instances driven in lockstep
module tb_pattern_serializer;
  import pattern_serializer_pkg::*;
  typedef struct {
    logic [7:0] pat;
    logic [3:0] reps;
    int         d2;
    int         d0;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t vecs[7];
  pattern_serializer_if #(.PAT_W(8), .CNT_W(4)) b ();
  pattern_serializer_if #(.PAT_W(8), .CNT_W(4)) b0 ();
  assign b0.start   = b.start;
  assign b0.abort   = b.abort;
  assign b0.pattern = b.pattern;
  assign b0.reps    = b.reps;
  pattern_serializer #(.PAT_W(8), .CNT_W(4), .GAP(2)) dut (.clk(clk), .rst(rst), .bus(b));
  pattern_serializer #(.PAT_W(8), .CNT_W(4), .GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [4:0] exp_out(logic [7:0] pat, int reps, int gap, int done_at, int k);
    int p, idx;
    logic v;
    if (k == done_at) return 5'b00001;
    if (k > done_at || reps == 0) return 5'b00000;
    p   = (k - 1) % (8 + gap);
    v   = p < 8;
    idx = v ? 7 - p : 0;
    return {v & pat[idx], v, v && p == 0, 1'b1, 1'b0};
  endfunction
  task automatic check(string nm, int k, logic [7:0] got, logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d got=%b exp=%b", nm, k, got, exp);
    end
  endtask
  task automatic chk_both(string nm, int k, logic [4:0] e2, logic [4:0] e0);
    check({nm, "/gap2"}, k, {3'b0, b.dout, b.dout_valid, b.frame_start, b.busy, b.done}, {3'b0, e2});
    check({nm, "/gap0"}, k, {3'b0, b0.dout, b0.dout_valid, b0.frame_start, b0.busy, b0.done}, {3'b0, e0});
  endtask
  task automatic run_vec(string nm, vec_t v);
    int n;
    n = v.d2 > v.d0 ? v.d2 : v.d0;
    b.pattern = v.pat;
    b.reps    = v.reps;
    b.start   = 1'b1;
    tick();
    b.start = 1'b0;
    for (int k = 1; k <= n + 1; k++) begin
      chk_both(nm, k, exp_out(v.pat, int'(v.reps), 2, v.d2, k), exp_out(v.pat, int'(v.reps), 0, v.d0, k));
      tick();
    end
  endtask
  initial begin
    vec_t v;
    vecs[0] = '{8'hB1, 4'd1, 9, 9};
    vecs[1] = '{8'hB1, 4'd3, 29, 25};
    vecs[2] = '{8'h5A, 4'd0, 1, 1};
    vecs[3] = '{8'hC3, 4'd2, 19, 17};
    vecs[4] = '{8'h01, 4'd15, 149, 121};
    vecs[5] = '{8'h80, 4'd1, 9, 9};
    vecs[6] = '{8'hFF, 4'd2, 19, 17};
    b.start   = 1'b0;
    b.abort   = 1'b0;
    b.pattern = '0;
    b.reps    = '0;
    tick();
    tick();
    chk_both("reset", 0, 5'b0, 5'b0);
    check("reset_state", 0, {6'b0, dut.state_q}, {6'b0, S_IDLE});
    rst = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);
    b.pattern = 8'h0F;
    b.reps    = 4'd1;
    b.start   = 1'b1;
    tick();
    b.start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      chk_both("ignore_busy_start", k, exp_out(8'h0F, 1, 2, 9, k), exp_out(8'h0F, 1, 0, 9, k));
      if (k == 3) begin
        b.start   = 1'b1;
        b.pattern = 8'hFF;
        b.reps    = 4'd3;
      end else if (k == 9) begin
        b.start = 1'b1;
        b.reps  = 4'd1;
      end else b.start = 1'b0;
      tick();
    end
    b.start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      chk_both("start_in_done", k, exp_out(8'hFF, 1, 2, 9, k), exp_out(8'hFF, 1, 0, 9, k));
      tick();
    end
    b.pattern = 8'hB1;
    b.reps    = 4'd2;
    b.start   = 1'b1;
    tick();
    b.start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk_both("pre_abort", k, exp_out(8'hB1, 2, 2, 19, k), exp_out(8'hB1, 2, 0, 17, k));
      if (k == 4) b.abort = 1'b1;
      tick();
    end
    b.abort = 1'b0;
    for (int k = 5; k <= 8; k++) begin
      chk_both("post_abort", k, 5'b0, 5'b0);
      tick();
    end
    b.pattern = 8'hFF;
    b.reps    = 4'd1;
    b.start   = 1'b1;
    b.abort   = 1'b1;
    tick();
    b.start = 1'b0;
    b.abort = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      chk_both("abort_beats_start", k, 5'b0, 5'b0);
      tick();
    end
    v = '{8'hB1, 4'd1, 9, 9};
    run_vec("after_abort", v);
    b.pattern = 8'hB1;
    b.reps    = 4'd3;
    b.start   = 1'b1;
    tick();
    b.start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      chk_both("pre_reset", k, exp_out(8'hB1, 3, 2, 29, k), exp_out(8'hB1, 3, 0, 25, k));
      if (k == 9) rst = 1'b0;
      tick();
    end
    rst = 1'b1;
    chk_both("mid_gap_reset", 10, 5'b0, 5'b0);
    check("reset_state_gap2", 10, {6'b0, dut.state_q}, {6'b0, S_IDLE});
    check("reset_state_gap0", 10, {6'b0, dut0.state_q}, {6'b0, S_IDLE});
    tick();
    chk_both("after_reset_idle", 11, 5'b0, 5'b0);
    v = '{8'h6D, 4'd1, 9, 9};
    run_vec("after_reset", v);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pattern_serializer.md
Name: pattern_serializer

Overview:
Serial bit-pattern transmitter: the transmitting end of the single-bit serial stream consumed by the team's sequence-detector blocks. It latches a parallel pattern and a repeat count on a start pulse and shifts the pattern out MSB first, one bit per clock. A fixed idle gap separates repetitions. Start/busy/done handshake to the controlling logic; dout/dout_valid feed a detector or a serial pin.

Parameters:
PAT_W, 8, pattern width in bits (>=2)
CNT_W, 4, repeat-count width
GAP, 2, idle cycles between repetitions (0 = back-to-back)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low
start  input  1  request; sampled only in IDLE or DONE
pattern  input  PAT_W  pattern to send, latched on accepted start
reps  input  CNT_W  repetition count, latched on accepted start
abort  input  1  synchronous cancel of an active transfer
dout  output  1  serial data bit (registered)
dout_valid  output  1  dout carries a pattern bit this cycle
frame_start  output  1  high with the first (MSB) bit of every repetition
busy  output  1  high in SHIFT and GAP
done  output  1  one-cycle pulse after the final bit

Behaviour:
- Reset (rst=0 at edge): state IDLE. dout, dout_valid, frame_start, busy and done all 0. Shift register and counters cleared. Applies mid-transfer; outputs are 0 from the next cycle.
- States: IDLE, SHIFT, GAP, DONE. All outputs are registered.
- IDLE/DONE with start=1 at edge N:
  - latch pattern into shadow and shift registers, load rep counter with reps;
  - reps!=0: SHIFT at N+1, first bit = pattern[PAT_W-1] with dout_valid=1 and frame_start=1;
  - reps==0: DONE at N+1 (done=1, no valid bits).
- SHIFT: one bit per cycle, MSB first, PAT_W cycles, bit counter 0..PAT_W-1. After bit PAT_W-1, decrement the rep counter, then:
  - remaining=0: DONE;
  - remaining>0 and GAP>0: GAP;
  - remaining>0 and GAP=0: reload from shadow and stay in SHIFT; next bit is the MSB with frame_start=1, no bubble.
- GAP: exactly GAP cycles with dout=0 and dout_valid=0, then reload from shadow and go to SHIFT.
- DONE: a single cycle with done=1 and busy=0.
  - start in DONE is accepted exactly as in IDLE, giving back-to-back transfers with one DONE cycle between them.
  - without start, go to IDLE.
- start while busy=1: ignored. The latched pattern and reps are unaffected.
- abort=1 while busy: IDLE next cycle, all outputs 0, no done pulse. abort in IDLE/DONE: no effect. abort and start in the same IDLE cycle: abort wins, start is ignored.
- When dout_valid=0, dout is 0.
- Timing per transfer: reps*PAT_W bit cycles plus (reps-1)*GAP gap cycles. done falls in the cycle after the last bit.

Decomposition:
- Shared package: state encoding localparams (IDLE, SHIFT, GAP, DONE as 2-bit codes), shared with the detector family for bench reuse.
- Sub-module piso_shift(PAT_W): loadable parallel-in/serial-out register with load, shift_en and msb output. The FSM and counters stay in pattern_serializer.

Test Plan:
1. PAT_W=8, pattern=8'hB1, reps=1, start at N -> dout=1,0,1,1,0,0,0,1 on N+1..N+8 with dout_valid=1; frame_start only at N+1; done=1 at N+9; busy=1 on N+1..N+8.
2. pattern=8'hB1, reps=3, GAP=2 -> bits on N+1..8, N+11..18 and N+21..28; valid=0 on N+9..10 and N+19..20; frame_start at N+1, N+11, N+21; done at N+29. With GAP=0, 24 contiguous bits and done at N+25.
3. reps=0, start at N -> no dout_valid; done=1 at N+1; busy never asserted.
4. start with pattern=8'hFF during transfer of 8'h0F (reps=1) -> ignored, output stays 0,0,0,0,1,1,1,1. start during the DONE cycle with 8'hFF -> eight 1s beginning the next cycle.
5. abort at the 4th bit of a reps=2 transfer -> next cycle busy=0, dout_valid=0; no done pulse; a new start then operates normally.
6. rst=0 mid-GAP, then released -> all outputs 0 and state IDLE. The next start with reps=1 produces exactly PAT_W bits and done.
